// File: rtl/output_uart_tx.sv
// Output-port UART: buffers 16-bit CPU output words in a FIFO and sends each
// one as two 8N1 frames (low byte first) on a registered, idle-high tx line.
module output_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [15:0]                  wr_data,
  input  logic                         wr_en,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy,
  output logic                         overflow,
  output logic                         tx
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned TCK_W = $clog2(CLKS_PER_BIT);
  localparam logic [TCK_W-1:0] LAST_TICK = TCK_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] ALMOST    = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state;
  logic [TCK_W-1:0]   tick;
  logic [2:0]         bit_idx;
  logic               byte_idx;
  logic [15:0]        shreg;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [15:0]        mem [DEPTH];
  logic               push;
  logic               pop;

  // Both decisions use registered state only: a push at full is dropped even
  // when the serializer pops in the same cycle.
  assign push = wr_en & ~full;
  assign pop  = (state == IDLE) && (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers, occupancy, full flag and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10: begin
          count <= count + CNT_W'(1);
          full  <= (count == ALMOST);
        end
        2'b01: begin
          count <= count - CNT_W'(1);
          full  <= 1'b0;
        end
        default: begin
          count <= count;
          full  <= full;
        end
      endcase
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  // Serializer: shreg shifts right once per data bit, so after the low byte
  // its bottom eight bits already hold the high byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      tick     <= '0;
      bit_idx  <= '0;
      byte_idx <= 1'b0;
      shreg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          tick <= '0;
          tx   <= 1'b1;
          if (pop) begin
            shreg    <= mem[rd_ptr];
            byte_idx <= 1'b0;
            bit_idx  <= '0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (tick == LAST_TICK) begin
            tick  <= '0;
            tx    <= shreg[0];
            state <= DATA;
          end else begin
            tick <= tick + TCK_W'(1);
          end
        end
        DATA: begin
          if (tick == LAST_TICK) begin
            tick  <= '0;
            shreg <= {1'b0, shreg[15:1]};
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[1];
            end
          end else begin
            tick <= tick + TCK_W'(1);
          end
        end
        STOP: begin
          if (tick == LAST_TICK) begin
            tick <= '0;
            if (!byte_idx) begin
              byte_idx <= 1'b1;
              bit_idx  <= '0;
              tx       <= 1'b0;
              state    <= START;
            end else begin
              tx    <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            tick <= tick + TCK_W'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_uart_tx.sv
// Bench for output_uart_tx: a frame-offset reference model checked every cycle,
// plus directed scenarios decoded from the recorded tx/busy history.
module tb_output_uart_tx;

  localparam int C     = 4;
  localparam int DEPTH = 4;
  localparam int WORD  = 20 * C;
  localparam int HIST  = 16384;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] wr_data;
  logic        wr_en;
  logic        full;
  logic [2:0]  count;
  logic        busy;
  logic        overflow;
  logic        tx;

  output_uart_tx #(.CLKS_PER_BIT(C), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .full(full),
    .count(count), .busy(busy), .overflow(overflow), .tx(tx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic tx_hist   [HIST];
  logic busy_hist [HIST];

  // Reference model: queue of words, and the offset into the current 20*C frame
  logic [15:0] mq[$];
  int          mpos  = -1;
  logic [15:0] mword = '0;
  logic        movf  = 1'b0;
  int          msz;
  bit          mpush;

  function automatic logic line_at(input logic [15:0] w, input int pos);
    int b, p;
    b = pos / (10 * C);
    p = (pos % (10 * C)) / C;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return w[b * 8 + p - 1];
  endfunction

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      mq.delete();
      mpos = -1;
      movf = 1'b0;
    end else begin
      msz   = mq.size();
      mpush = wr_en && (msz < DEPTH);
      if (wr_en && msz == DEPTH) movf = 1'b1;
      if (mpos < 0) begin
        if (msz != 0) begin
          mword = mq.pop_front();
          mpos  = 0;
        end
      end else begin
        mpos = mpos + 1;
        if (mpos == WORD) mpos = -1;
      end
      if (mpush) mq.push_back(wr_data);
    end
  end

  // Per-cycle comparison against the model, plus history capture
  logic e_tx;
  initial forever begin
    @(negedge clk);
    if (cyc < HIST) begin
      tx_hist[cyc]   = tx;
      busy_hist[cyc] = busy;
    end
    e_tx = (mpos < 0) ? 1'b1 : line_at(mword, mpos);
    checks = checks + 1;
    if (tx !== e_tx || busy !== (mpos >= 0) || count !== 3'(mq.size()) ||
        full !== (mq.size() == DEPTH) || overflow !== movf) begin
      errors = errors + 1;
      $display("FAIL cycle %0d model: tx %b/%b busy %b/%b count %0d/%0d full %b/%b ovf %b/%b (dut/expected)",
               cyc, tx, e_tx, busy, (mpos >= 0), count, mq.size(), full,
               (mq.size() == DEPTH), overflow, movf);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Caller sits at posedge+1; leaves wr_en high for the next word
  task automatic put(input logic [15:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!busy && count == 3'd0) return;
    end
    errors = errors + 1;
    $display("FAIL wait_done: timeout after %0d cycles, busy=%b count=%0d", max, busy, count);
  endtask

  function automatic logic [15:0] decode(input int s);
    logic [15:0] w;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 8; i++)
        w[b * 8 + i] = tx_hist[s + b * 10 * C + (1 + i) * C + C / 2];
    return w;
  endfunction

  int starts[$];
  task automatic scan(input int from, input int to);
    starts.delete();
    for (int c = from + 1; c <= to && c < HIST; c++)
      if (busy_hist[c] && !busy_hist[c - 1]) starts.push_back(c);
  endtask

  int k, s, r, c, zeros;
  logic [15:0] w[6];

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_count", count, 0);
    chk("reset_full", full, 0);
    chk("reset_ovf", overflow, 0);
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("idle_tx", tx, 1);

    // Single word
    k = cyc;
    put(16'hA55A);
    wr_en = 1'b0;
    wait_done(200);
    scan(k, cyc);
    chk("single_frames", starts.size(), 1);
    s = (starts.size() > 0) ? starts[0] : k;
    chk("single_latency", s - k, 2);
    chk("single_start_bit", tx_hist[s + C / 2], 0);
    chk("single_word", decode(s), 16'hA55A);
    chk("single_stop0", tx_hist[s + 9 * C + C / 2], 1);
    chk("single_start1", tx_hist[s + 10 * C + C / 2], 0);
    c = s;
    while (c < cyc && busy_hist[c]) c++;
    chk("single_busy_len", c - s, 80);

    // Fill and overflow
    for (int i = 0; i < 6; i++) w[i] = 16'($urandom);
    k = cyc;
    put(w[0]);
    wr_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 1; i <= 4; i++) put(w[i]);
    chk("fill_count", count, 4);
    chk("fill_full", full, 1);
    chk("fill_ovf_before", overflow, 0);
    put(w[5]);
    wr_en = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 4);
    wait_done(1000);
    scan(k, cyc);
    chk("fill_frames", starts.size(), 5);
    for (int i = 0; i < 5 && i < starts.size(); i++) begin
      chk($sformatf("fill_word%0d", i), decode(starts[i]), w[i]);
      if (i > 0) chk($sformatf("fill_gap%0d", i), starts[i] - starts[i - 1], WORD + 1);
    end

    // Push/pop collision in the IDLE pop cycle
    for (int i = 0; i < 4; i++) w[i] = 16'($urandom);
    k = cyc;
    put(w[0]);
    wr_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    put(w[1]);
    put(w[2]);
    wr_en = 1'b0;
    chk("coll_pre_count", count, 2);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("coll_idle", busy, 0);
    chk("coll_idle_count", count, 2);
    wr_en = 1'b1;
    wr_data = w[3];
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    chk("coll_count", count, 2);
    chk("coll_busy", busy, 1);
    wait_done(1000);
    scan(k, cyc);
    chk("coll_frames", starts.size(), 4);
    for (int i = 0; i < 4 && i < starts.size(); i++)
      chk($sformatf("coll_word%0d", i), decode(starts[i]), w[i]);

    // Reset during the high byte's data bits with two words queued
    k = cyc;
    put(16'h1234);
    put(16'h5678);
    put(16'h9ABC);
    wr_en = 1'b0;
    repeat (51) @(posedge clk);
    #2;
    chk("midrst_pre_count", count, 2);
    chk("midrst_pre_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_count", count, 0);
    chk("midrst_full", full, 0);
    chk("midrst_ovf", overflow, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    r = cyc;
    repeat (100) @(posedge clk);
    #1;
    zeros = 0;
    for (int i = r; i < cyc; i++) if (!tx_hist[i] || busy_hist[i]) zeros++;
    chk("postrst_quiet", zeros, 0);
    chk("postrst_count", count, 0);

    // Random traffic, checked cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      wr_en   = ($urandom_range(0, 39) == 0);
      wr_data = 16'($urandom);
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0;
    wait_done(2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_uart_tx.md
# output_uart_tx

Downstream consumer of the 16-bit CPU's output port. It captures each word the CPU writes to its output buffer into a small FIFO, then serializes it off-chip on a single UART 8N1 line: low byte first, then high byte. It decouples the single-cycle CPU write from the slow serial link and flags any words lost to overflow.

## Interface

Parameters:
- CLKS_PER_BIT, 16: clock cycles per UART bit. Must be ≥2.
- DEPTH, 4: FIFO depth in 16-bit words. Must be a power of 2 and ≥2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset. rst=0 resets the block immediately, independent of clk.
- wr_data  in  16  word from the CPU output path (same value driven onto ext_output).
- wr_en  in  1  one-cycle write strobe, asserted in the cycle the CPU commits an output write.
- full  out  1  FIFO holds DEPTH words.
- count  out  $clog2(DEPTH+1)  current FIFO occupancy.
- busy  out  1  serializer not in IDLE.
- overflow  out  1  sticky; set when a write is dropped.
- tx  out  1  UART serial line, idle high.

## Operation

- FIFO
  - Push when wr_en=1 and full=0.
  - If wr_en=1 and full=1, the write is dropped and overflow sets. It is cleared only by reset.
  - full is based on the registered count. A push at full is dropped even if a pop occurs in the same cycle.
  - Simultaneous push and pop with 0<count<DEPTH: count is unchanged, and both operations take effect.
  - Read and write pointers wrap modulo DEPTH.
- Serializer FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If count≠0, pop the head word into a 16-bit shift register, clear the byte index, and go to START next cycle.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: shift out 8 bits of the current byte, LSB first, each held for CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If the byte index is 0 (low byte just sent), set it to 1 and go to START to send bits [15:8]. Otherwise go to IDLE.
- busy=1 in START, DATA and STOP. busy=0 in IDLE.
- tx is driven from a register, so it is glitch-free.
- The bit-period counter is $clog2(CLKS_PER_BIT) bits wide. It counts 0..CLKS_PER_BIT-1 and resets on every state or bit change.

## Timing

- Reset values: tx=1, busy=0, full=0, count=0, overflow=0, FIFO pointers=0, FSM=IDLE.
- Reset mid-frame: tx returns to 1 and busy to 0 immediately. All FIFO contents are discarded.
- Write visibility: wr_en in cycle N gives count incremented in cycle N+1.
- Latency from wr_en (empty FIFO, FSM IDLE) to the first tx=0: 2 cycles. The strobe is at N, the pop in IDLE at N+1, and START begins at N+2.
- Per word: 20×CLKS_PER_BIT cycles of frames, then at least 1 IDLE cycle with tx=1.
- Back-to-back words therefore start every 20×CLKS_PER_BIT+1 cycles.
- No idle gap between the low-byte and high-byte frames: the STOP of byte 0 is followed directly by the START of byte 1.
- count decrements in the cycle after the IDLE pop. A pop and a push in the same cycle net to zero.

## Test plan

- Reset: drive rst=0 mid-operation with random inputs → immediately tx=1, busy=0, count=0, full=0, overflow=0. After release, tx stays 1 with no writes.
- Single word, CLKS_PER_BIT=4: write 0xA55A at cycle N.
  - tx=0 from N+2 for 4 cycles.
  - Then bits 0,1,0,1,1,0,1,0 (0x5A), stop=1.
  - Then start, then bits 1,0,1,0,0,1,0,1 (0xA5), stop.
  - busy falls exactly 80 cycles after N+2.
- Fill and overflow, DEPTH=4: write 5 words on consecutive cycles while the serializer is busy → full=1 after the 4th write, the 5th is dropped, overflow=1. The 4 words are transmitted in order and the 5th never appears.
- Push/pop collision: with count=2, assert wr_en in the IDLE pop cycle → count stays 2, and word ordering is preserved.
- Back-to-back, CLKS_PER_BIT=4: two queued words → the second start bit begins exactly 81 cycles after the first.
- Reset mid-frame: assert rst during DATA of the high byte with 2 words queued → tx=1 at once. After release there is no further transmission and count=0.
